// File: rtl/ex_mem_register.sv
// ============================================================================
// Module   : ex_mem_register
// Brief    : EX/MEM pipeline stage; captures ALU results, resolves branches,
//            builds store lanes and flags misaligned memory accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_register #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_zero,
  input  logic [WIDTH-1:0] i_reg_b,
  input  logic [WIDTH-1:0] i_branch_target,
  input  logic [REGW-1:0]  i_write_reg,
  input  logic             i_reg_write,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic             i_mem_to_reg,
  input  logic             i_branch,
  input  logic [1:0]       i_mem_size,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_addr,
  output logic [WIDTH-1:0] o_store_data,
  output logic [3:0]       o_byte_en,
  output logic [REGW-1:0]  o_write_reg,
  output logic             o_reg_write,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_mem_to_reg,
  output logic             o_branch_taken,
  output logic [WIDTH-1:0] o_branch_target,
  output logic             o_align_err
);

  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_BYTE = 2'b10;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_mis_raw;
  logic               w_mis;
  logic               w_wr_ok;
  logic [WIDTH-1:0]   w_store_data;
  logic [3:0]         w_lane_en;

  logic [WIDTH-1:0]   r_addr;
  logic [WIDTH-1:0]   r_store_data;
  logic [3:0]         r_byte_en;
  logic [REGW-1:0]    r_write_reg;
  logic               r_reg_write;
  logic               r_mem_read;
  logic               r_mem_write;
  logic               r_mem_to_reg;
  logic               r_branch_taken;
  logic [WIDTH-1:0]   r_branch_target;
  logic               r_align_err;

  // Size decode: code 11 falls into the word path alongside 00.
  always_comb begin
    w_mis_raw    = 1'b0;
    w_store_data = i_reg_b;
    w_lane_en    = 4'b1111;
    case (i_mem_size)
      c_SIZE_HALF: begin
        w_mis_raw    = i_alu_result[0];
        w_store_data = {2{i_reg_b[15:0]}};
        w_lane_en    = i_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      c_SIZE_BYTE: begin
        w_mis_raw    = 1'b0;
        w_store_data = {4{i_reg_b[7:0]}};
        w_lane_en    = 4'b0001 << i_alu_result[1:0];
      end
      default: begin
        w_mis_raw    = |i_alu_result[1:0];
        w_store_data = i_reg_b;
        w_lane_en    = 4'b1111;
      end
    endcase
    w_mis   = w_mis_raw & (i_mem_read | i_mem_write);
    w_wr_ok = i_mem_write & ~w_mis;
  end

  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = EMPTY;
    end else if (!i_stall) begin
      w_state_next = FULL;
    end
  end

  // Flush has priority over stall so the hazard unit can always squash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= EMPTY;
      r_addr          <= '0;
      r_store_data    <= '0;
      r_byte_en       <= 4'b0000;
      r_write_reg     <= '0;
      r_reg_write     <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_branch_taken  <= 1'b0;
      r_branch_target <= '0;
      r_align_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (i_flush) begin
        r_addr          <= '0;
        r_store_data    <= '0;
        r_byte_en       <= 4'b0000;
        r_write_reg     <= '0;
        r_reg_write     <= 1'b0;
        r_mem_read      <= 1'b0;
        r_mem_write     <= 1'b0;
        r_mem_to_reg    <= 1'b0;
        r_branch_taken  <= 1'b0;
        r_branch_target <= '0;
        r_align_err     <= 1'b0;
      end else if (!i_stall) begin
        r_addr          <= i_alu_result;
        r_store_data    <= w_store_data;
        r_byte_en       <= w_wr_ok ? w_lane_en : 4'b0000;
        r_write_reg     <= i_write_reg;
        r_reg_write     <= i_reg_write & ~(w_mis & i_mem_read);
        r_mem_read      <= i_mem_read & ~w_mis;
        r_mem_write     <= w_wr_ok;
        r_mem_to_reg    <= i_mem_to_reg;
        r_branch_taken  <= i_branch & i_zero;
        r_branch_target <= i_branch_target;
        r_align_err     <= w_mis;
      end
    end
  end

  assign o_valid         = (r_state == FULL);
  assign o_addr          = r_addr;
  assign o_store_data    = r_store_data;
  assign o_byte_en       = r_byte_en;
  assign o_write_reg     = r_write_reg;
  assign o_reg_write     = r_reg_write;
  assign o_mem_read      = r_mem_read;
  assign o_mem_write     = r_mem_write;
  assign o_mem_to_reg    = r_mem_to_reg;
  assign o_branch_taken  = r_branch_taken;
  assign o_branch_target = r_branch_target;
  assign o_align_err     = r_align_err;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_register.sv
// ============================================================================
// Module   : tb_ex_mem_register
// Brief    : Scoreboard bench for ex_mem_register against a byte-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_register;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic [31:0] alu_result, reg_b, branch_target;
  logic [4:0]  write_reg;
  logic        reg_write, mem_read, mem_write, mem_to_reg, branch, zero;
  logic [1:0]  mem_size;

  logic        d_valid, d_reg_write, d_mem_read, d_mem_write, d_mem_to_reg;
  logic        d_branch_taken, d_align_err;
  logic [31:0] d_addr, d_store_data, d_branch_target;
  logic [3:0]  d_byte_en;
  logic [4:0]  d_write_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [3:0]  be;
    logic [4:0]  wreg;
    logic        rw, rd, wr, m2r, tk;
    logic [31:0] bt;
    logic        al;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  ex_mem_register #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_flush(flush),
    .i_alu_result(alu_result), .i_zero(zero), .i_reg_b(reg_b),
    .i_branch_target(branch_target), .i_write_reg(write_reg),
    .i_reg_write(reg_write), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_mem_to_reg(mem_to_reg), .i_branch(branch), .i_mem_size(mem_size),
    .o_valid(d_valid), .o_addr(d_addr), .o_store_data(d_store_data),
    .o_byte_en(d_byte_en), .o_write_reg(d_write_reg), .o_reg_write(d_reg_write),
    .o_mem_read(d_mem_read), .o_mem_write(d_mem_write), .o_mem_to_reg(d_mem_to_reg),
    .o_branch_taken(d_branch_taken), .o_branch_target(d_branch_target),
    .o_align_err(d_align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Access size in bytes; the legal lane offset is the address rounded down to it.
  function automatic exp_t model();
    exp_t e;
    int   nb;
    int   off;
    bit   mis;
    e   = '0;
    nb  = (mem_size == 2'b01) ? 2 : (mem_size == 2'b10) ? 1 : 4;
    off = int'(alu_result[1:0]);
    mis = (mem_read || mem_write) && (off % nb != 0);
    off = off - (off % nb);
    e.valid = 1'b1;
    e.addr  = alu_result;
    e.wreg  = write_reg;
    e.bt    = branch_target;
    e.m2r   = mem_to_reg;
    e.tk    = branch && zero;
    e.al    = mis;
    e.rd    = mem_read && !mis;
    e.wr    = mem_write && !mis;
    e.rw    = reg_write && !(mis && mem_read);
    if (nb == 4)      e.sd = reg_b;
    else if (nb == 2) e.sd = 32'(reg_b[15:0]) * 32'h0001_0001;
    else              e.sd = 32'(reg_b[7:0]) * 32'h0101_0101;
    e.be = e.wr ? 4'(((1 << nb) - 1) << off) : 4'b0000;
    return e;
  endfunction

  task automatic go();
    if (flush)       cur = '0;
    else if (!stall) cur = model();
    q.push_back(cur);
  endtask

  task automatic next();
    @(negedge clk);
    stall = 0; flush = 0; alu_result = 0; reg_b = 0; branch_target = 0;
    write_reg = 0; reg_write = 0; mem_read = 0; mem_write = 0;
    mem_to_reg = 0; branch = 0; zero = 0; mem_size = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, d_valid, 0);
    chk({tag, "_addr"}, d_addr, 0);
    chk({tag, "_sd"}, d_store_data, 0);
    chk({tag, "_be"}, d_byte_en, 0);
    chk({tag, "_wreg"}, d_write_reg, 0);
    chk({tag, "_ctl"}, {d_reg_write, d_mem_read, d_mem_write, d_mem_to_reg,
                        d_branch_taken, d_align_err}, 0);
    chk({tag, "_bt"}, d_branch_target, 0);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("valid", d_valid, mon_e.valid);
      chk("addr", d_addr, mon_e.addr);
      chk("store_data", d_store_data, mon_e.sd);
      chk("byte_en", d_byte_en, mon_e.be);
      chk("write_reg", d_write_reg, mon_e.wreg);
      chk("reg_write", d_reg_write, mon_e.rw);
      chk("mem_read", d_mem_read, mon_e.rd);
      chk("mem_write", d_mem_write, mon_e.wr);
      chk("mem_to_reg", d_mem_to_reg, mon_e.m2r);
      chk("branch_taken", d_branch_taken, mon_e.tk);
      chk("branch_target", d_branch_target, mon_e.bt);
      chk("align_err", d_align_err, mon_e.al);
    end
  end

  initial begin
    // Asynchronous reset with every input nonzero, before any clock edge.
    rst_n = 0; stall = 0; flush = 0;
    alu_result = 32'hFFFF_FFFF; reg_b = 32'hFFFF_FFFF; branch_target = 32'hFFFF_FFFF;
    write_reg = 5'h1F; reg_write = 1; mem_read = 1; mem_write = 1;
    mem_to_reg = 1; branch = 1; zero = 1; mem_size = 2'b11;
    #1;
    check_zero("reset_async");
    cur = '0;
    #6 rst_n = 1;

    next(); alu_result = 32'h10; reg_write = 1; go();
    @(posedge clk); #2;
    chk("plan_reset_addr", d_addr, 32'h10);
    chk("plan_reset_valid", d_valid, 1);

    next(); mem_write = 1; mem_size = 2'b10; alu_result = 32'h103; reg_b = 32'hAABBCCDD; go();
    @(posedge clk); #2;
    chk("plan_byte_sd", d_store_data, 32'hDDDDDDDD);
    chk("plan_byte_be", d_byte_en, 4'b1000);

    next(); mem_write = 1; mem_size = 2'b01; alu_result = 32'h102; reg_b = 32'h1234ABCD; go();
    @(posedge clk); #2;
    chk("plan_half_sd", d_store_data, 32'hABCDABCD);
    chk("plan_half_be", d_byte_en, 4'b1100);
    next(); mem_write = 1; mem_size = 2'b01; alu_result = 32'h101; reg_b = 32'h1234ABCD; go();
    @(posedge clk); #2;
    chk("plan_half_mis", {d_align_err, d_mem_write, d_byte_en}, 6'b100000);

    next(); mem_read = 1; mem_size = 2'b00; alu_result = 32'h202; reg_write = 1; go();
    @(posedge clk); #2;
    chk("plan_load_mis", {d_mem_read, d_reg_write, d_align_err}, 3'b001);

    next(); branch = 1; zero = 1; branch_target = 32'h40; go();
    next(); branch = 1; zero = 0; branch_target = 32'h40; go();

    // Word store, three stalled edges with moving inputs, then stall+flush.
    next(); mem_write = 1; alu_result = 32'h300; reg_b = 32'hCAFEF00D; go();
    for (int i = 0; i < 3; i++) begin
      next(); stall = 1; alu_result = $urandom; reg_b = $urandom; mem_write = 1;
      reg_write = 1; write_reg = 5'(i + 3); go();
    end
    next(); stall = 1; flush = 1; mem_write = 1; alu_result = 32'h400; go();

    // Reset asserted while stalled clears without a clock edge.
    next(); mem_write = 1; alu_result = 32'h500; reg_b = 32'h55; go();
    next(); stall = 1; go();
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check_zero("reset_in_stall");
    cur = '0;
    #1 rst_n = 1;

    for (int n = 0; n < 400; n++) begin
      next();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      alu_result = $urandom; reg_b = $urandom; branch_target = $urandom;
      write_reg = 5'($urandom); mem_size = 2'($urandom);
      reg_write = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
      mem_to_reg = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom);
      go();
    end

    next();
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_mem_register.md
# ex_mem_register

Execute-to-memory pipeline stage that sits directly downstream of the 32-bit ALU. It captures the ALU result, the Zero flag and the execute-stage control bits each cycle, and resolves the branch decision from Zero. It pre-computes store byte enables and replicated store data, and detects misaligned accesses. Stall and flush inputs from the hazard unit hold the stage or turn it into a bubble.

## Interface
- WIDTH, 32, datapath width; only 32 is supported.
- REGW, 5, register-file address width.

- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hold all stage registers.
- Flush  in  1  load a bubble.
- ALUResult  in  32  ALU result; memory address for loads and stores.
- Zero  in  1  ALU Zero flag; 1 means the branch condition is met.
- RegB  in  32  store data (rt value after forwarding).
- BranchTarget  in  32  computed branch target PC.
- WriteReg  in  REGW  destination register.
- RegWrite, MemRead, MemWrite, MemToReg, Branch  in  1 each  execute-stage control.
- MemSize  in  2  00 word, 01 half, 10 byte; 11 is treated as word.
- Valid_o  out  1  stage holds a real instruction.
- Addr_o  out  32  registered ALUResult.
- StoreData_o  out  32  aligned store data.
- ByteEn_o  out  4  store byte enables; bit 0 is address offset 0 (little-endian).
- WriteReg_o  out  REGW  destination register.
- RegWrite_o, MemRead_o, MemWrite_o, MemToReg_o  out  1 each  control, gated as below.
- BranchTaken_o  out  1  registered branch decision.
- BranchTarget_o  out  32  registered target.
- AlignErr_o  out  1  misaligned access captured.

## Operation
- Loaded values on a normal edge (Stall=0, Flush=0):
  - Valid_o is set to 1.
  - Addr_o, WriteReg_o, BranchTarget_o and MemToReg_o load their inputs.
  - BranchTaken_o loads Branch & Zero.
- Misalignment (mis):
  - word: ALUResult[1:0] != 00.
  - half: ALUResult[0] = 1.
  - byte: never misaligned.
  - Applies only when MemRead or MemWrite is 1.
- Gated controls:
  - AlignErr_o loads mis.
  - MemRead_o loads MemRead & ~mis; MemWrite_o loads MemWrite & ~mis.
  - RegWrite_o loads RegWrite & ~(mis & MemRead).
- Store data and enables:
  - word: StoreData_o = RegB, ByteEn_o = 1111.
  - half: StoreData_o = {RegB[15:0], RegB[15:0]}; ByteEn_o = 0011 if ALUResult[1] = 0, else 1100.
  - byte: StoreData_o = {4{RegB[7:0]}}; ByteEn_o = 0001 << ALUResult[1:0].
  - ByteEn_o = 0000 whenever MemWrite_o would be 0.
- Flush: a bubble loads.
  - Valid_o, RegWrite_o, MemRead_o, MemWrite_o, MemToReg_o, BranchTaken_o, AlignErr_o all go to 0.
  - ByteEn_o goes to 0000.
  - Data fields (Addr_o, StoreData_o, BranchTarget_o, WriteReg_o) are don't-care; the implementation clears them to 0.
- Stall: every register keeps its value.
- Stall and Flush together: Flush wins and a bubble loads.
- Branch handling: the stage does not self-flush on a taken branch. The hazard unit consumes BranchTaken_o and drives Flush on upstream stages.
- There is no state machine beyond the Valid_o bit (two states, EMPTY and FULL):
  - EMPTY to FULL on a normal edge.
  - FULL to EMPTY on Flush.
  - Stall holds the current state.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on outputs after edge N, stable until edge N+1.
- All outputs are registered; there is no combinational path from input to output.
- Reset is asynchronous and active-low. While Reset = 0:
  - every output is 0, including ByteEn_o = 0000 and Addr_o = 0.
  - the stage holds a bubble.
- Deasserting Reset mid-cycle: the first capture happens on the next rising edge.
- Reset asserted during a stall clears immediately, without waiting for a clock edge.
- Stall held for K cycles keeps outputs frozen for K edges; capture resumes on the first edge with Stall = 0.

## Test plan
- Reset: drive Reset = 0 with all inputs nonzero -> every output 0 without any clock edge; Reset = 1, then ALUResult = 0x10, RegWrite = 1 -> after 1 edge Addr_o = 0x10, RegWrite_o = 1, Valid_o = 1.
- Byte store: MemWrite = 1, MemSize = 10, ALUResult = 0x103, RegB = 0xAABBCCDD -> StoreData_o = 0xDDDDDDDD, ByteEn_o = 1000, AlignErr_o = 0.
- Half store: ALUResult = 0x102, RegB = 0x1234ABCD -> ByteEn_o = 1100, StoreData_o = 0xABCDABCD. Then ALUResult = 0x101 -> AlignErr_o = 1, MemWrite_o = 0, ByteEn_o = 0000.
- Misaligned load: MemRead = 1, MemSize = 00, ALUResult = 0x202, RegWrite = 1 -> MemRead_o = 0, RegWrite_o = 0, AlignErr_o = 1.
- Branch: Branch = 1, Zero = 1, BranchTarget = 0x40 -> BranchTaken_o = 1, BranchTarget_o = 0x40. Next cycle Zero = 0 -> BranchTaken_o = 0.
- Stall and flush: load a word store; hold Stall = 1 for 3 edges while inputs change -> outputs unchanged. Then Stall = 1 with Flush = 1 -> Valid_o = 0, MemWrite_o = 0, ByteEn_o = 0000.
